alu_arbiter: RTL and testbench

Shares one combinational ALU (operand width WIDTH, 3-bit operation select) between two requesters. It accepts one operation at a time over a valid/ready handshake and drives the ALU from registered operands. It captures the result and zero flag, then returns them to the issuing requester over a valid/ready response channel. It sits between the ALU and two clients, such as the main datapath and an address/branch unit.

---
 rtl/alu_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter for one shared combinational ALU; ALU_ARB_ROUND_ROBIN_EN selects round-robin arbitration
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_sel,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             owner;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;
    logic [2:0]       opnd_sel;
    logic [WIDTH-1:0] res_q;
    logic             zero_q;
    logic             win1;
    logic             take0;
    logic             take1;
    logic             take;
    logic             rsp_done;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic ptr;

    // Pointer names the requester favoured on the next collision; it moves away from whoever was just granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (take) begin
            ptr <= take0;
        end
    end

    assign win1 = req1_valid & (~req0_valid | ptr);
`else
    // Fixed priority: requester 1 only wins when requester 0 is idle
    assign win1 = req1_valid & ~req0_valid;
`endif

    // Grants are only offered in IDLE; valids gate them, so no ready without a request
    assign take0    = (state == IDLE) & req0_valid & ~win1;
    assign take1    = (state == IDLE) & win1;
    assign take     = take0 | take1;
    assign rsp_done = (state == RESP) & (owner ? rsp1_ready : rsp0_ready);

    assign req0_ready = take0;
    assign req1_ready = take1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: one accept cycle, one ALU cycle, then hold the response until taken
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (take) begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                state_nx = RESP;
            end
            RESP: begin
                if (rsp_done) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operand registers and owner load only on an accepted request, so the ALU inputs hold through RESP and IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= 1'b0;
            opnd_a   <= '0;
            opnd_b   <= '0;
            opnd_sel <= 3'b000;
        end else if (take0) begin
            owner    <= 1'b0;
            opnd_a   <= req0_a;
            opnd_b   <= req0_b;
            opnd_sel <= req0_sel;
        end else if (take1) begin
            owner    <= 1'b1;
            opnd_a   <= req1_a;
            opnd_b   <= req1_b;
            opnd_sel <= req1_sel;
        end
    end

    // Response registers capture the ALU at the closing edge of EXEC; sel is never decoded here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            zero_q <= 1'b0;
        end else if (state == EXEC) begin
            res_q  <= alu_result;
            zero_q <= alu_zero;
        end
    end

    assign alu_a   = opnd_a;
    assign alu_b   = opnd_b;
    assign alu_sel = opnd_sel;

    // Both response ports show the shared registers; only the owner's valid qualifies them
    assign rsp0_valid  = (state == RESP) & ~owner;
    assign rsp1_valid  = (state == RESP) & owner;
    assign rsp0_result = res_q;
    assign rsp1_result = res_q;
    assign rsp0_zero   = zero_q;
    assign rsp1_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed scoreboard bench for alu_arbiter
module tb_alu_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_sel, req1_sel;
    logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [W-1:0] rsp0_result, rsp1_result;
    logic         rsp0_zero, rsp1_zero;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]   alu_sel;
    logic         alu_zero;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int           port;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   sel;
        logic [W-1:0] result;
        logic         zero;
    } exp_t;

    exp_t sb[$];

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    // Simple ALU: 000 AND, 001 OR, 010 ADD, 110 SUB, others 0
    always_comb begin
        alu_result = '0;
        case (alu_sel)
            3'b000:  alu_result = alu_a & alu_b;
            3'b001:  alu_result = alu_a | alu_b;
            3'b010:  alu_result = alu_a + alu_b;
            3'b110:  alu_result = alu_a - alu_b;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ready(input int p);
        return (p == 0) ? req0_ready : req1_ready;
    endfunction

    function automatic logic other_ready(input int p);
        return (p == 0) ? req1_ready : req0_ready;
    endfunction

    task automatic set_req(input int p, input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s);
        if (p == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_sel = s;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_sel = s;
        end
    endtask

    task automatic drop_req(input int p);
        if (p == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    // Called at negedge: raise request p, wait up to max_wait cycles for ready, push expectation, step into EXEC
    task automatic accept(input int p, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s,
                          input logic [W-1:0] er, input int max_wait, input bit keep);
        int   n;
        exp_t e;
        n = 0;
        set_req(p, 1'b1, a, b, s);
        #1;
        while (!get_ready(p) && n < max_wait) begin
            @(negedge clk); #1; n++;
        end
        chk($sformatf("req%0d_ready", p), 64'(get_ready(p)), 64'd1);
        if (!get_ready(p)) begin
            drop_req(p);
            return;
        end
        chk($sformatf("req%0d_other_ready", p), 64'(other_ready(p)), 64'd0);
        e.port = p; e.a = a; e.b = b; e.sel = s; e.result = er; e.zero = (er == '0);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (!keep) drop_req(p);
        #1;
        chk("exec_alu_a", 64'(alu_a), 64'(a));
        chk("exec_alu_b", 64'(alu_b), 64'(b));
        chk("exec_alu_sel", 64'(alu_sel), 64'(s));
        chk("exec_no_rsp", 64'({rsp0_valid, rsp1_valid}), 64'd0);
        chk("exec_no_ready", 64'({req0_ready, req1_ready}), 64'd0);
    endtask

    // Wait for a response, compare with scoreboard head, hold rsp_ready low for hold cycles, then complete
    task automatic wait_rsp(input int hold, input int exp_lat);
        int   n;
        int   p;
        exp_t e;
        n = 0;
        while (!(rsp0_valid || rsp1_valid) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("rsp_valid_seen", 64'(rsp0_valid | rsp1_valid), 64'd1);
        if (!(rsp0_valid || rsp1_valid)) return;
        chk("rsp_latency", 64'(n), 64'(exp_lat));
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        p = rsp1_valid ? 1 : 0;
        chk("rsp_port", 64'(p), 64'(e.port));
        chk("rsp_one_hot", 64'({rsp0_valid, rsp1_valid}), (e.port == 0) ? 64'd2 : 64'd1);
        for (int i = 0; i < hold; i++) begin
            chk("bp_valid", 64'((p == 0) ? rsp0_valid : rsp1_valid), 64'd1);
            chk("bp_result", 64'((p == 0) ? rsp0_result : rsp1_result), 64'(e.result));
            chk("bp_no_ready", 64'({req0_ready, req1_ready}), 64'd0);
            @(negedge clk); #1;
        end
        chk("rsp_result", 64'((p == 0) ? rsp0_result : rsp1_result), 64'(e.result));
        chk("rsp_zero", 64'((p == 0) ? rsp0_zero : rsp1_zero), 64'(e.zero));
        chk("resp_alu_a", 64'(alu_a), 64'(e.a));
        chk("resp_alu_b", 64'(alu_b), 64'(e.b));
        chk("resp_alu_sel", 64'(alu_sel), 64'(e.sel));
        if (p == 0) rsp0_ready = 1'b1;
        else        rsp1_ready = 1'b1;
        #1;
        chk("resp_no_ready", 64'({req0_ready, req1_ready}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        #1;
        chk("rsp_done", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        set_req(0, 1'b0, '0, '0, 3'b000);
        set_req(1, 1'b0, '0, '0, 3'b000);
        @(negedge clk); #1;
        chk("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
        chk("rst_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'd0);
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        chk("rst_alu_sel", 64'(alu_sel), 64'd0);
        chk("rst_result", 64'(rsp0_result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Both valid from reset: req0 wins first
        set_req(1, 1'b1, 32'd12, 32'd10, 3'b001);
        accept(0, 32'd12, 32'd10, 3'b000, 32'd8, 0, 1'b1);
        wait_rsp(0, 1);
`ifdef ALU_ARB_ROUND_ROBIN_EN
        accept(1, 32'd12, 32'd10, 3'b001, 32'd14, 0, 1'b0);
        drop_req(0);
        wait_rsp(0, 1);
`else
        accept(0, 32'd12, 32'd10, 3'b000, 32'd8, 0, 1'b0);
        wait_rsp(0, 1);
        accept(1, 32'd12, 32'd10, 3'b001, 32'd14, 0, 1'b0);
        wait_rsp(0, 1);
`endif

        // Single request: 5 + 3
        accept(0, 32'd5, 32'd3, 3'b010, 32'd8, 0, 1'b0);
        wait_rsp(0, 1);

        // Backpressure on rsp1 with req0 waiting
        accept(1, 32'd7, 32'd2, 3'b110, 32'd5, 0, 1'b0);
        set_req(0, 1'b1, 32'd1, 32'd1, 3'b010);
        wait_rsp(4, 1);
        accept(0, 32'd1, 32'd1, 3'b010, 32'd2, 0, 1'b0);
        wait_rsp(0, 1);

        // Subtract to zero
        accept(0, 32'd9, 32'd9, 3'b110, 32'd0, 0, 1'b0);
        wait_rsp(2, 1);

        // Undefined sel forwarded
        accept(1, 32'd6, 32'd3, 3'b011, 32'd0, 0, 1'b0);
        wait_rsp(0, 1);

        // Reset during EXEC drops the transaction
        accept(0, 32'd4, 32'd4, 3'b010, 32'd8, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'd0);
        chk("mid_rst_alu_a", 64'(alu_a), 64'd0);
        chk("mid_rst_alu_b", 64'(alu_b), 64'd0);
        chk("mid_rst_alu_sel", 64'(alu_sel), 64'd0);
        chk("mid_rst_result", 64'(rsp0_result), 64'd0);
        chk("mid_rst_zero", 64'(rsp0_zero), 64'd0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("post_rst_no_rsp", 64'({rsp0_valid, rsp1_valid}), 64'd0);
        end
        accept(1, 32'd3, 32'd4, 3'b010, 32'd7, 0, 1'b0);
        wait_rsp(0, 1);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
